// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between the UART FIFOs and the internal register/memory bus.
// Parses 'W'/'R' binary commands, runs one bus cycle, and returns a one-byte response.
module uart_cmd_ctrl #(
    parameter int TIMEOUT = 65535,
    parameter int TO_BIT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_empty,
    input  logic [7:0]  r_data,
    output logic        rd_uart,
    input  logic        tx_full,
    output logic        wr_uart,
    output logic [7:0]  w_data,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic        bus_rvalid,
    input  logic [7:0]  bus_rdata,
    output logic        busy,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, GET_AH, GET_AL, GET_D, BUS_WR, BUS_RD, WAIT_RD, SEND
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_BAD = 8'h3F;
    localparam logic [7:0] RSP_TO  = 8'h21;
    localparam logic [TO_BIT-1:0] TO_LAST = TO_BIT'(TIMEOUT - 1);

    state_t             state;
    logic               is_read;
    logic [TO_BIT-1:0]  to_cnt;
    logic               to_hit;

    assign to_hit = (to_cnt == TO_LAST);

    always_comb begin
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        case (state)
            IDLE, GET_AH, GET_AL, GET_D: rd_uart = ~rx_empty;
            SEND:                        wr_uart = ~tx_full;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            is_read   <= 1'b0;
            to_cnt    <= '0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            w_data    <= '0;
            bus_we    <= 1'b0;
            bus_re    <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            bus_we <= 1'b0;
            bus_re <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (rd_uart) begin
                        busy <= 1'b1;
                        if (r_data == OP_WR || r_data == OP_RD) begin
                            is_read <= (r_data == OP_RD);
                            state   <= GET_AH;
                        end else begin
                            w_data <= RSP_BAD;
                            err    <= 1'b1;
                            state  <= SEND;
                        end
                    end
                end
                GET_AH, GET_AL, GET_D: begin
                    // A consumed byte is progress and takes priority over expiry.
                    if (rd_uart) begin
                        to_cnt <= '0;
                        case (state)
                            GET_AH: begin
                                bus_addr[15:8] <= r_data;
                                state          <= GET_AL;
                            end
                            GET_AL: begin
                                bus_addr[7:0] <= r_data;
                                if (is_read) begin
                                    bus_re <= 1'b1;
                                    state  <= BUS_RD;
                                end else begin
                                    state <= GET_D;
                                end
                            end
                            default: begin
                                bus_wdata <= r_data;
                                bus_we    <= 1'b1;
                                state     <= BUS_WR;
                            end
                        endcase
                    end else if (to_hit) begin
                        to_cnt <= '0;
                        err    <= 1'b1;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                BUS_WR: begin
                    w_data <= RSP_OK;
                    state  <= SEND;
                end
                BUS_RD: begin
                    to_cnt <= '0;
                    state  <= WAIT_RD;
                end
                WAIT_RD: begin
                    if (bus_rvalid) begin
                        to_cnt <= '0;
                        w_data <= bus_rdata;
                        state  <= SEND;
                    end else if (to_hit) begin
                        to_cnt <= '0;
                        w_data <= RSP_TO;
                        err    <= 1'b1;
                        state  <= SEND;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                SEND: begin
                    to_cnt <= '0;
                    if (wr_uart) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: FIFO/bus environment models, a command-level
// reference model feeding expectation queues, and a monitor that checks DUT outputs.
module tb_uart_cmd_ctrl;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx_empty;
    logic [7:0]  r_data;
    logic        rd_uart;
    logic        tx_full;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we;
    logic        bus_re;
    logic        bus_rvalid;
    logic [7:0]  bus_rdata;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT(TO), .TO_BIT(16)) dut (
        .clk(clk), .reset(reset),
        .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
        .tx_full(tx_full), .wr_uart(wr_uart), .w_data(w_data),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_re(bus_re),
        .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .busy(busy), .err(err)
    );

    int checks = 0;
    int passed = 0;

    logic [7:0]  rx_q[$];
    logic [7:0]  exp_tx[$];
    logic [23:0] exp_wr[$];
    logic [15:0] exp_rd[$];
    logic [7:0]  ref_mem[logic [15:0]];
    logic [7:0]  dev_mem[logic [15:0]];
    int exp_err = 0, err_cycles = 0;
    int exp_we = 0, we_cycles = 0;

    bit gaps_on = 0, tx_rand = 0, tx_force = 0;
    int rd_mode = 1;  // 0: random delay + junk pulse, 1: fixed 3 cycles, 2: never

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act);
        checks++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    function automatic logic [7:0] dflt(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] dev_rd(input logic [15:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : dflt(a);
    endfunction

    // Reference model: command-level effects of each command
    task automatic issue_write(input logic [15:0] a, input logic [7:0] d);
        rx_q.push_back(8'h57); rx_q.push_back(a[15:8]); rx_q.push_back(a[7:0]); rx_q.push_back(d);
        exp_wr.push_back({a, d});
        exp_tx.push_back(8'h4B);
        ref_mem[a] = d;
        exp_we++;
    endtask

    task automatic issue_read(input logic [15:0] a, input bit no_resp);
        rx_q.push_back(8'h52); rx_q.push_back(a[15:8]); rx_q.push_back(a[7:0]);
        exp_rd.push_back(a);
        if (no_resp) begin
            exp_tx.push_back(8'h21);
            exp_err++;
        end else begin
            exp_tx.push_back(ref_mem.exists(a) ? ref_mem[a] : dflt(a));
        end
    endtask

    task automatic issue_bad(input logic [7:0] b);
        rx_q.push_back(b);
        exp_tx.push_back(8'h3F);
        exp_err++;
    endtask

    task automatic preload(input logic [15:0] a, input logic [7:0] d);
        ref_mem[a] = d;
        dev_mem[a] = d;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(rx_q.size() == 0 && exp_tx.size() == 0 && !busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) fail("wait_idle_timeout", n);
        repeat (2) @(negedge clk);
    endtask

    // RX FIFO and TX FIFO environment
    initial begin
        rx_empty = 1'b1;
        r_data   = 8'h00;
        tx_full  = 1'b0;
        forever begin
            bit pop;
            @(negedge clk);
            pop = rd_uart;
            @(posedge clk);
            #1;
            if (pop && rx_q.size() > 0) void'(rx_q.pop_front());
            rx_empty = (rx_q.size() == 0) || (gaps_on && $urandom_range(0, 3) == 0);
            r_data   = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
            tx_full  = tx_force || (tx_rand && $urandom_range(0, 2) == 0);
        end
    end

    // Bus device
    initial begin
        int rv_cnt;
        logic [15:0] rd_addr;
        rv_cnt     = -1;
        rd_addr    = '0;
        bus_rvalid = 1'b0;
        bus_rdata  = 8'h00;
        forever begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (rv_cnt > 0) rv_cnt--;
            if (rv_cnt == 0) begin
                bus_rvalid = 1'b1;
                bus_rdata  = dev_rd(rd_addr);
                rv_cnt     = -1;
            end
            if (bus_re && !reset) begin
                rd_addr = bus_addr;
                case (rd_mode)
                    0: begin
                        rv_cnt = $urandom_range(1, 4);
                        if ($urandom_range(0, 1) == 1) begin
                            bus_rvalid = 1'b1;
                            bus_rdata  = ~dev_rd(bus_addr);
                        end
                    end
                    1:       rv_cnt = 3;
                    default: rv_cnt = -1;
                endcase
            end
        end
    end

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wr_uart) begin
                    if (exp_tx.size() == 0) fail("tx_unexpected", w_data);
                    else chk("tx_byte", w_data, exp_tx.pop_front());
                end
                if (bus_we) begin
                    we_cycles++;
                    if (exp_wr.size() == 0) fail("bus_we_unexpected", bus_addr);
                    else begin
                        logic [23:0] e;
                        e = exp_wr.pop_front();
                        chk("bus_we_addr", bus_addr, e[23:8]);
                        chk("bus_we_data", bus_wdata, e[7:0]);
                    end
                    dev_mem[bus_addr] = bus_wdata;
                end
                if (bus_re) begin
                    if (exp_rd.size() == 0) fail("bus_re_unexpected", bus_addr);
                    else chk("bus_re_addr", bus_addr, exp_rd.pop_front());
                end
                if (err) err_cycles++;
            end
        end
    end

    task automatic check_reset_values(input string tag);
        chk({tag, "_bus_addr"}, bus_addr, 16'h0000);
        chk({tag, "_bus_wdata"}, bus_wdata, 8'h00);
        chk({tag, "_w_data"}, w_data, 8'h00);
        chk({tag, "_bus_we"}, bus_we, 1'b0);
        chk({tag, "_bus_re"}, bus_re, 1'b0);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_wr_uart"}, wr_uart, 1'b0);
    endtask

    initial begin
        int n, bcnt, w0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Plain write
        issue_write(16'h1234, 8'hA5);
        wait_idle(200);

        // Plain read, device answers 3 cycles after bus_re
        preload(16'h00FF, 8'h3C);
        issue_read(16'h00FF, 1'b0);
        wait_idle(200);

        // Bad opcode followed by a good write
        issue_bad(8'h00);
        issue_write(16'h0042, 8'h99);
        wait_idle(200);

        // Byte-gap timeout: 57 12 then silence
        rx_q.push_back(8'h57); rx_q.push_back(8'h12);
        exp_err++;
        bcnt = 0;
        repeat (60) begin
            @(negedge clk);
            if (busy) bcnt++;
        end
        chk("gap_timeout_busy_cycles", bcnt, TO + 1);
        chk("gap_timeout_idle", busy, 1'b0);

        // Read timeout: device never answers
        rd_mode = 2;
        issue_read(16'h0A0B, 1'b1);
        wait_idle(200);
        rd_mode = 1;

        // TX backpressure in SEND
        tx_force = 1;
        w0 = we_cycles;
        issue_write(16'hBEEF, 8'h77);
        n = 0;
        while (we_cycles == w0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("bp_bus_we_wait", n);
        repeat (10) begin
            @(negedge clk);
            chk("bp_wr_uart_low", wr_uart, 1'b0);
            chk("bp_w_data_hold", w_data, 8'h4B);
        end
        tx_force = 0;
        wait_idle(200);

        // Reset while waiting for the data byte
        rx_q.push_back(8'h57); rx_q.push_back(8'h13); rx_q.push_back(8'h37);
        n = 0;
        while (rx_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail("rst_fill_wait", n);
        repeat (2) @(negedge clk);
        chk("rst_busy_before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_values("midcmd_reset");
        @(posedge clk); #1 reset = 1'b0;
        issue_write(16'h1337, 8'h5E);
        issue_read(16'h1337, 1'b0);
        wait_idle(300);

        // Randomized back-to-back traffic with RX gaps, TX backpressure and read latency
        gaps_on = 1; tx_rand = 1; rd_mode = 0;
        for (int i = 0; i < 60; i++) begin
            int kind;
            logic [15:0] a;
            logic [7:0]  b;
            kind = $urandom_range(0, 9);
            a = ($urandom_range(0, 1) == 1) ? {8'h20, 5'b0, 3'($urandom_range(0, 7))}
                                            : 16'($urandom);
            if (kind < 4) issue_write(a, 8'($urandom));
            else if (kind < 8) issue_read(a, 1'b0);
            else begin
                b = 8'($urandom);
                while (b == 8'h57 || b == 8'h52) b = 8'($urandom);
                issue_bad(b);
            end
        end
        wait_idle(6000);
        gaps_on = 0; tx_rand = 0;
        repeat (5) @(negedge clk);

        chk("err_cycles", err_cycles, exp_err);
        chk("bus_we_cycles", we_cycles, exp_we);
        chk("tx_left", exp_tx.size(), 0);
        chk("wr_left", exp_wr.size(), 0);
        chk("rd_left", exp_rd.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
